// File: rtl/silly_unit.sv
// Registered 3-input logic-function block: y = silly function, z = odd parity.
// Optional saturating y/z high-count statistics, enabled by defining SILLY_STATS_EN.
module silly_unit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             y,
  output logic             z,
  output logic [CNT_W-1:0] y_cnt,
  output logic [CNT_W-1:0] z_cnt
);

  logic y_next;
  logic z_next;

  always_comb begin
    y_next = (~b & ~c) | (a & ~b);
    z_next = a ^ b ^ c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y <= 1'b0;
      z <= 1'b0;
    end else begin
      y <= y_next;
      z <= z_next;
    end
  end

`ifdef SILLY_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Counters stick at all-ones until the next reset; they never wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_cnt <= '0;
      z_cnt <= '0;
    end else begin
      if (y_next && (y_cnt != CNT_MAX)) y_cnt <= y_cnt + 1'b1;
      if (z_next && (z_cnt != CNT_MAX)) z_cnt <= z_cnt + 1'b1;
    end
  end
`else
  assign y_cnt = '0;
  assign z_cnt = '0;
`endif

endmodule

// File: tb/tb_silly_unit.sv
// Directed self-checking bench for silly_unit; counter expectations follow SILLY_STATS_EN.
module tb_silly_unit;

  localparam int CNT_W = 8;
`ifdef SILLY_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             a;
  logic             b;
  logic             c;
  logic             y;
  logic             z;
  logic [CNT_W-1:0] y_cnt;
  logic [CNT_W-1:0] z_cnt;

  int tests;
  int fails;

  silly_unit #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .c     (c),
    .y     (y),
    .z     (z),
    .y_cnt (y_cnt),
    .z_cnt (z_cnt)
  );

  // clock/reset block: 20 ns period
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // drive on the falling edge, sample 1 ns after the rising edge
  task automatic step(input logic rst, input logic [2:0] abc);
    @(negedge clk);
    reset = rst;
    {a, b, c} = abc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CNT_W-1:0] exp_cnt(input int n);
    if (!STATS) return '0;
    if (n > 255) return 8'd255;
    return n[CNT_W-1:0];
  endfunction

  task automatic test_reset();
    step(1'b1, 3'b111);
    step(1'b1, 3'b111);
    tests++;
    if (y !== 1'b0) begin fails++; $display("FAIL reset_y actual=%b required=0", y); end
    tests++;
    if (z !== 1'b0) begin fails++; $display("FAIL reset_z actual=%b required=0", z); end
    tests++;
    if (y_cnt !== '0) begin fails++; $display("FAIL reset_y_cnt actual=%0d required=0", y_cnt); end
    tests++;
    if (z_cnt !== '0) begin fails++; $display("FAIL reset_z_cnt actual=%0d required=0", z_cnt); end
  endtask

  task automatic test_sweep();
    logic [7:0] ty;
    logic [7:0] tz;
    int yc [8];
    int zc [8];
    ty = 8'b0011_0001;  // bit i = y for abc=i
    tz = 8'b1001_0110;
    yc = '{1, 1, 1, 1, 2, 3, 3, 3};
    zc = '{0, 1, 2, 2, 3, 3, 3, 4};
    for (int i = 0; i < 8; i++) begin
      step(1'b0, i[2:0]);
      tests++;
      if (y !== ty[i]) begin fails++; $display("FAIL sweep_y abc=%03b actual=%b required=%b", i[2:0], y, ty[i]); end
      tests++;
      if (z !== tz[i]) begin fails++; $display("FAIL sweep_z abc=%03b actual=%b required=%b", i[2:0], z, tz[i]); end
      tests++;
      if (y_cnt !== exp_cnt(yc[i])) begin
        fails++; $display("FAIL sweep_y_cnt abc=%03b actual=%0d required=%0d", i[2:0], y_cnt, exp_cnt(yc[i]));
      end
      tests++;
      if (z_cnt !== exp_cnt(zc[i])) begin
        fails++; $display("FAIL sweep_z_cnt abc=%03b actual=%0d required=%0d", i[2:0], z_cnt, exp_cnt(zc[i]));
      end
    end
  endtask

  // starts from y_cnt=3, z_cnt=4 left by the sweep
  task automatic test_saturation();
    for (int i = 1; i <= 260; i++) begin
      step(1'b0, 3'b100);
      if (i == 251 || i == 252 || i == 260) begin
        tests++;
        if (y !== 1'b1 || z !== 1'b1) begin
          fails++; $display("FAIL sat_yz cycle=%0d actual=%b%b required=11", i, y, z);
        end
        tests++;
        if (y_cnt !== exp_cnt(3 + i)) begin
          fails++; $display("FAIL sat_y_cnt cycle=%0d actual=%0d required=%0d", i, y_cnt, exp_cnt(3 + i));
        end
        tests++;
        if (z_cnt !== exp_cnt(4 + i)) begin
          fails++; $display("FAIL sat_z_cnt cycle=%0d actual=%0d required=%0d", i, z_cnt, exp_cnt(4 + i));
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    step(1'b1, 3'b000);
    tests++;
    if (y !== 1'b0 || z !== 1'b0) begin fails++; $display("FAIL mid_reset_yz actual=%b%b required=00", y, z); end
    tests++;
    if (y_cnt !== '0 || z_cnt !== '0) begin
      fails++; $display("FAIL mid_reset_cnt actual=%0d/%0d required=0/0", y_cnt, z_cnt);
    end
    step(1'b0, 3'b000);
    tests++;
    if (y !== 1'b1 || z !== 1'b0) begin fails++; $display("FAIL resume_yz actual=%b%b required=10", y, z); end
    tests++;
    if (y_cnt !== exp_cnt(1) || z_cnt !== exp_cnt(0)) begin
      fails++; $display("FAIL resume_cnt actual=%0d/%0d required=%0d/%0d", y_cnt, z_cnt, exp_cnt(1), exp_cnt(0));
    end
  endtask

  // continues from y_cnt=1, z_cnt=0
  task automatic test_back_to_back();
    logic [2:0] abc [4];
    logic [1:0] yz  [4];
    int yc [4];
    int zc [4];
    abc = '{3'b101, 3'b011, 3'b110, 3'b001};
    yz  = '{2'b10, 2'b00, 2'b00, 2'b01};
    yc  = '{2, 2, 2, 2};
    zc  = '{0, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, abc[i]);
      tests++;
      if ({y, z} !== yz[i]) begin
        fails++; $display("FAIL b2b_yz abc=%03b actual=%b%b required=%b", abc[i], y, z, yz[i]);
      end
      tests++;
      if (y_cnt !== exp_cnt(yc[i]) || z_cnt !== exp_cnt(zc[i])) begin
        fails++; $display("FAIL b2b_cnt abc=%03b actual=%0d/%0d required=%0d/%0d",
                          abc[i], y_cnt, z_cnt, exp_cnt(yc[i]), exp_cnt(zc[i]));
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    {a, b, c} = 3'b111;
    test_reset();
    test_sweep();
    test_saturation();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
